// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
// Valid/ready operand input, valid/ready result output; divide-by-zero is flagged.
module seq_divider #(
  parameter int unsigned BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] dividend,
  input  logic [BW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] quotient,
  output logic [BW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] dvd_q, dvd_d;
  logic [BW-1:0] dvs_q, dvs_d;
  logic [BW-1:0] rem_q, rem_d;
  logic [BW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] quo_out_q, quo_out_d;
  logic [BW-1:0] rem_out_q, rem_out_d;
  logic          dbz_q, dbz_d;

  logic [BW:0]   rem_shift;
  logic [BW:0]   trial;

  // The stored remainder is always < divisor, so its bit BW is always zero
  // and only the low BW bits need to be kept between steps.
  assign rem_shift = {rem_q, dvd_q[cnt_q]};
  assign trial     = rem_shift - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dvd_d = dividend;
          dvs_d = divisor;
          if (divisor == '0) begin
            quo_out_d = '1;
            rem_out_d = dividend;
            dbz_d     = 1'b1;
            state_d   = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CW'(BW - 1);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (!trial[BW]) begin
          rem_d        = trial[BW-1:0];
          quo_d[cnt_q] = 1'b1;
        end else begin
          rem_d        = rem_shift[BW-1:0];
          quo_d[cnt_q] = 1'b0;
        end
        if (cnt_q == '0) begin
          quo_out_d = quo_d;
          rem_out_d = rem_d;
          dbz_d     = 1'b0;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
    end
  end

  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and swept checks of seq_divider (BW=8) against hand-computed values
// and the language's own / and % operators.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;
  int n;

  seq_divider #(.BW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then performs one input handshake.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Counts edges from the handshake until out_valid; toggles junk inputs while busy.
  task automatic wait_out(output int edges, input bit noisy);
    edges = 0;
    while (!out_valid && edges < 50) begin
      step();
      edges++;
      if (noisy && !out_valid) begin
        in_valid = 1'($urandom);
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] a, b;
    logic [7:0] corner [3];
    corner[0] = 8'd0;
    corner[1] = 8'd1;
    corner[2] = 8'hff;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    dividend = '0;
    divisor = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    step();

    // 100/7
    send(8'd100, 8'd7);
    check("t1_busy_in_ready", in_ready, 0);
    wait_out(n, 1'b0);
    check("t1_latency", n, 8);
    check("t1_quotient", quotient, 14);
    check("t1_remainder", remainder, 2);
    check("t1_dbz", div_by_zero, 0);
    step();
    check("t1_after_out_valid", out_valid, 0);
    check("t1_after_in_ready", in_ready, 1);
    check("t1_hold_quotient", quotient, 14);

    // 255/1 then 5/9 back-to-back
    send(8'd255, 8'd1);
    wait_out(n, 1'b0);
    check("t2a_quotient", quotient, 255);
    check("t2a_remainder", remainder, 0);
    check("t2a_in_ready_done", in_ready, 0);
    in_valid = 1'b1;
    dividend = 8'd5;
    divisor  = 8'd9;
    step();
    check("t2_in_ready_after_hs", in_ready, 1);
    check("t2_not_accepted_at_hs", out_valid, 0);
    step();
    in_valid = 1'b0;
    check("t2b_accepted", in_ready, 0);
    wait_out(n, 1'b0);
    check("t2b_latency", n, 8);
    check("t2b_quotient", quotient, 0);
    check("t2b_remainder", remainder, 5);
    step();

    // 37/0
    send(8'd37, 8'd0);
    n = 1;
    if (!out_valid) begin
      wait_out(n, 1'b0);
      n++;
    end
    check("t3_latency", n, 1);
    check("t3_quotient", quotient, 8'hff);
    check("t3_remainder", remainder, 37);
    check("t3_dbz", div_by_zero, 1);
    step();

    // 200/13 with backpressure
    out_ready = 1'b0;
    send(8'd200, 8'd13);
    wait_out(n, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_in_ready", in_ready, 0);
      check("t4_hold_quotient", quotient, 15);
      check("t4_hold_remainder", remainder, 5);
    end
    out_ready = 1'b1;
    step();
    check("t4_release_in_ready", in_ready, 1);
    check("t4_release_out_valid", out_valid, 0);

    // Reset in the middle of 250/3
    send(8'd250, 8'd3);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_quotient", quotient, 0);
    check("t5_rst_remainder", remainder, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_no_result", out_valid, 0);
    end
    send(8'd9, 8'd4);
    wait_out(n, 1'b0);
    check("t5_quotient", quotient, 2);
    check("t5_remainder", remainder, 1);
    step();

    // Sweep with corners and noisy inputs while busy
    for (int i = 0; i < 600; i++) begin
      a = (i % 4 < 3) ? corner[i % 3] : 8'($urandom);
      b = ((i / 4) % 4 < 3) ? corner[(i / 4) % 3] : 8'($urandom);
      if (i % 5 == 4) a = 8'($urandom);
      if (i % 7 == 6) b = 8'($urandom);
      send(a, b);
      wait_out(n, 1'b1);
      check("sw_valid", out_valid, 1);
      if (b == 0) begin
        check("sw_dbz_quotient", quotient, 8'hff);
        check("sw_dbz_remainder", remainder, a);
        check("sw_dbz_flag", div_by_zero, 1);
      end else begin
        check("sw_quotient", quotient, a / b);
        check("sw_remainder", remainder, a % b);
        check("sw_flag", div_by_zero, 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
